fetch_unit: RTL and testbench

- Front-end fetch stage: generates sequential PCs, issues instruction-memory requests, matches in-order responses to their PCs, and presents {pc, instr} packets downstream with valid/ready.
- Output feeds the fetch→decode skid buffer; stalls arrive via out_ready.
- Backend redirects (branch mispredict, exception) flush all fetched and in-flight wrong-path instructions and restart at the redirect PC.

---
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Front-end fetch stage. Generates sequential PCs, issues instruction-memory
// requests, pairs the in-order memory responses with the PCs that requested
// them, and hands {pc, instr} packets to the fetch->decode skid buffer with a
// valid/ready handshake. A backend redirect flushes everything fetched or in
// flight and restarts fetch at the redirect PC.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   imem_req_valid    request valid
//   imem_req_ready    memory accepts the request
//   imem_req_addr     request address (current fetch PC)
//   imem_resp_valid   response valid (never back-pressured)
//   imem_resp_data    instruction word of the oldest outstanding request
//   redirect_valid    flush and restart at redirect_pc
//   redirect_pc       restart address
//   out_valid         packet valid to the skid buffer
//   out_ready         skid buffer accepts the packet
//   out_pc, out_instr packet contents (head slot, combinational)
//
// Every request owns one queue slot from issue until its packet is
// dequeued, so the slot queue doubles as the outstanding-request limiter.
// Three pointers walk the queue: tail (next slot to allocate on issue),
// fill (next slot to receive a response) and head (next slot to emit).
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam int              PW      = $clog2(MAX_OUTSTANDING);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  // Control state (reset)
  logic [XLEN-1:0]            fetch_pc;
  logic [PW-1:0]              head_ptr;
  logic [PW-1:0]              fill_ptr;
  logic [PW-1:0]              tail_ptr;
  logic [CW-1:0]              occupancy;
  logic [CW-1:0]              unfilled_cnt;
  logic [CW-1:0]              drop_count;
  logic [MAX_OUTSTANDING-1:0] slot_filled;

  // Slot payload (not reset; only read once the slot is marked filled)
  logic [XLEN-1:0] slot_pc    [MAX_OUTSTANDING];
  logic [XLEN-1:0] slot_instr [MAX_OUTSTANDING];

  logic                       issue_fire;
  logic                       resp_accept;
  logic                       resp_drop;
  logic                       deq_fire;
  logic [CW-1:0]              outstanding_total;
  logic [CW-1:0]              redirect_drop;
  logic [MAX_OUTSTANDING-1:0] slot_filled_nxt;
  logic [CW-1:0]              issue_ext;
  logic [CW-1:0]              deq_ext;
  logic [CW-1:0]              accept_ext;

  // Request side: occupancy is the registered value, so a dequeue from a
  // full queue only re-enables issue on the following cycle.
  assign imem_req_valid = !reset && !redirect_valid && (occupancy < MAX_CNT);
  assign imem_req_addr  = reset ? RESET_PC : fetch_pc;
  assign issue_fire     = imem_req_valid && imem_req_ready;

  // Response side: stale responses (owed to requests issued before a
  // redirect) are counted down in drop_count and never reach a slot.
  assign resp_accept = imem_resp_valid && (drop_count == '0) && !redirect_valid;
  assign resp_drop   = imem_resp_valid && (drop_count != '0);

  // Output side: a response lands in a slot on the clock edge, so it is
  // visible here no earlier than the cycle after it arrived.
  assign out_valid = !reset && !redirect_valid && slot_filled[head_ptr];
  assign out_pc    = slot_pc[head_ptr];
  assign out_instr = slot_instr[head_ptr];
  assign deq_fire  = out_valid && out_ready;

  assign issue_ext  = {{PW{1'b0}}, issue_fire};
  assign deq_ext    = {{PW{1'b0}}, deq_fire};
  assign accept_ext = {{PW{1'b0}}, resp_accept};

  // Responses still owed by memory: requests in unfilled slots plus those
  // already written off by earlier redirects. A response arriving in the
  // redirect cycle itself settles one of them.
  always_comb begin
    outstanding_total = unfilled_cnt + drop_count;
    redirect_drop     = outstanding_total;
    if (imem_resp_valid && (outstanding_total != '0)) begin
      redirect_drop = outstanding_total - CNT_ONE;
    end
  end

  // Issue, fill and dequeue never touch the same slot in one cycle:
  // tail==head only when empty (no dequeue) or full (no issue), and the
  // fill slot is always unfilled, so it can be neither head-filled nor tail.
  always_comb begin
    slot_filled_nxt = slot_filled;
    if (issue_fire) begin
      slot_filled_nxt[tail_ptr] = 1'b0;
    end
    if (resp_accept) begin
      slot_filled_nxt[fill_ptr] = 1'b1;
    end
    if (deq_fire) begin
      slot_filled_nxt[head_ptr] = 1'b0;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      head_ptr     <= '0;
      fill_ptr     <= '0;
      tail_ptr     <= '0;
      occupancy    <= '0;
      unfilled_cnt <= '0;
      drop_count   <= '0;
      slot_filled  <= '0;
    end else if (redirect_valid) begin
      fetch_pc     <= redirect_pc;
      head_ptr     <= '0;
      fill_ptr     <= '0;
      tail_ptr     <= '0;
      occupancy    <= '0;
      unfilled_cnt <= '0;
      drop_count   <= redirect_drop;
      slot_filled  <= '0;
    end else begin
      if (issue_fire) begin
        fetch_pc <= fetch_pc + PC_STEP;
        tail_ptr <= tail_ptr + 1'b1;
      end
      if (resp_accept) begin
        fill_ptr <= fill_ptr + 1'b1;
      end
      if (deq_fire) begin
        head_ptr <= head_ptr + 1'b1;
      end
      if (resp_drop) begin
        drop_count <= drop_count - CNT_ONE;
      end
      occupancy    <= occupancy + issue_ext - deq_ext;
      unfilled_cnt <= unfilled_cnt + issue_ext - accept_ext;
      slot_filled  <= slot_filled_nxt;
    end
  end

  // Slot payload
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      slot_pc[tail_ptr] <= fetch_pc;
    end
    if (resp_accept) begin
      slot_instr[fill_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. An in-order instruction-memory model with a
// programmable latency answers requests; a scoreboard holds the packets the
// bench expects (its own PC model plus a fixed address->word function) and
// is popped on every output handshake. A second instance with a wrapping
// reset PC shares all inputs and has its request addresses checked.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_out_valid;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_instr;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .MAX_OUTSTANDING(4)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(w_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_pc(w_out_pc), .out_instr(w_out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          cyc;
  int          mem_lat;
  int          issue_cnt;
  int          deq_cnt;
  logic [31:0] exp_pc;
  logic [31:0] last_deq_pc;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] sb_pc     [$];
  logic [31:0] sb_instr  [$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock cycle: observe the settled cycle at the falling edge, then
  // cross the rising edge and present the memory response for the new cycle.
  task automatic step();
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_pc);
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + mem_lat);
      sb_pc.push_back(exp_pc);
      sb_instr.push_back(word_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      issue_cnt++;
    end
    if (out_valid && out_ready) begin
      if (sb_pc.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL pkt_unexpected observed pc=%h expected=no packet", out_pc);
      end else begin
        chk("pkt_pc", out_pc, sb_pc.pop_front());
        chk("pkt_instr", out_instr, sb_instr.pop_front());
      end
      last_deq_pc = out_pc;
      deq_cnt++;
    end
    if (imem_resp_valid && pend_addr.size() > 0) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (redirect_valid && !reset) begin
      chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("redir_out_valid", {31'd0, out_valid}, 32'd0);
      sb_pc.delete();
      sb_instr.delete();
      exp_pc = redirect_pc;
    end
    if (reset) begin
      sb_pc.delete();
      sb_instr.delete();
      pend_addr.delete();
      pend_due.delete();
      exp_pc = 32'h0000_0000;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word_of(pend_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
  endtask

  // One-cycle synchronous reset; returns in the first cycle after it.
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    settle();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
    step();
    reset = 1'b0;
  endtask

  task automatic wait_deq(input string tag, input int budget);
    int d0;
    int n;
    d0 = deq_cnt;
    n  = 0;
    while (deq_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (deq_cnt != d0) else begin
      errors++;
      $error("FAIL %s observed=timeout expected=packet within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int i0;
    checks = 0; errors = 0; cyc = 0; mem_lat = 1;
    issue_cnt = 0; deq_cnt = 0; exp_pc = 32'h0; last_deq_pc = 32'h0;
    reset = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    out_ready = 1'b1;
    step();

    // Straight-line fetch, 1-cycle memory; wrap instance checked alongside
    do_reset();
    settle();
    chk("wrap_valid0", {31'd0, w_req_valid}, 32'd1);
    chk("wrap_addr0", w_req_addr, 32'hFFFF_FFF8);
    step(); settle();
    chk("wrap_addr1", w_req_addr, 32'hFFFF_FFFC);
    step(); settle();
    chk("wrap_addr2", w_req_addr, 32'h0000_0000);
    repeat (10) step();
    d0 = deq_cnt;
    repeat (8) step();
    chk("stream_rate", 32'(deq_cnt - d0), 32'd8);

    // Backpressure: four requests, then stall; release drains in order
    out_ready = 1'b0;
    do_reset();
    i0 = issue_cnt;
    repeat (8) step();
    settle();
    chk("bp_issued", 32'(issue_cnt - i0), 32'd4);
    chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_out_pc", out_pc, 32'h0000_0000);
    out_ready = 1'b1;
    settle();
    chk("bp_full_deq_no_issue", {31'd0, imem_req_valid}, 32'd0);
    step(); settle();
    chk("bp_resume_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("bp_resume_addr", imem_req_addr, 32'h0000_0010);
    repeat (8) step();

    // Redirect with two unanswered requests, 3-cycle memory
    mem_lat = 3;
    do_reset();
    step(); step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    settle();
    chk("redir_drop_count", 32'(dut.drop_count), 32'd2);
    chk("redir_new_addr", imem_req_addr, 32'h0000_0100);
    wait_deq("redir_first_pkt", 20);
    chk("redir_first_pc", last_deq_pc, 32'h0000_0100);
    chk("redir_drop_done", 32'(dut.drop_count), 32'd0);
    repeat (4) step();

    // Redirect coinciding with a response and a held packet
    mem_lat   = 1;
    out_ready = 1'b0;
    do_reset();
    step(); step();
    settle();
    chk("coinc_held_valid", {31'd0, out_valid}, 32'd1);
    chk("coinc_resp_present", {31'd0, imem_resp_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    settle();
    chk("coinc_out_valid_after", {31'd0, out_valid}, 32'd0);
    chk("coinc_occupancy", 32'(dut.occupancy), 32'd0);
    chk("coinc_drop_count", 32'(dut.drop_count), 32'd0);
    out_ready = 1'b1;
    wait_deq("coinc_first_pkt", 10);
    chk("coinc_first_pc", last_deq_pc, 32'h0000_0200);
    repeat (3) step();

    // Back-to-back redirects: last PC wins, drop count recomputed
    mem_lat = 3;
    do_reset();
    step(); step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    step();
    redirect_pc = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    settle();
    chk("b2b_drop_count", 32'(dut.drop_count), 32'd1);
    chk("b2b_new_addr", imem_req_addr, 32'h0000_0400);
    wait_deq("b2b_first_pkt", 20);
    chk("b2b_first_pc", last_deq_pc, 32'h0000_0400);
    repeat (4) step();

    // Reset mid-stream with three occupied slots
    mem_lat   = 1;
    out_ready = 1'b0;
    do_reset();
    step(); step(); step();
    settle();
    chk("mid_occupancy", 32'(dut.occupancy), 32'd3);
    do_reset();
    settle();
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_req_addr", imem_req_addr, 32'h0000_0000);
    chk("mid_occ_cleared", 32'(dut.occupancy), 32'd0);
    out_ready = 1'b1;
    wait_deq("mid_first_pkt", 10);
    chk("mid_first_pc", last_deq_pc, 32'h0000_0000);
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
